// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for the EX stage (RISC-V M DIV/DIVU/REM/REMU).
// Define DIV_FAST_EN to retire divide-by-zero and |divisor| > |dividend| cases without iterating.
module ex_div #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_flush,
    input  logic            div_req,
    input  logic            div_sign,
    input  logic            div_res_sel,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            div_ack,
    output logic            div_stall,
    output logic            div_valid,
    output logic            div_busy,
    output logic [XLEN-1:0] div_result
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [XLEN-1:0] OneX = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              sel_q, sel_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN-1:0]   dvd_abs, dvs_abs;
    logic              dvd_neg, dvs_neg;
    logic [XLEN:0]     shifted;
    logic [XLEN-1:0]   diff;
    logic              borrow;
    logic [XLEN-1:0]   q_fix, r_fix;

    always_comb begin
        dvd_neg = div_sign & dividend[XLEN-1];
        dvs_neg = div_sign & divisor[XLEN-1];
        dvd_abs = dvd_neg ? (~dividend + OneX) : dividend;
        dvs_abs = dvs_neg ? (~divisor + OneX) : divisor;

        // Shifted partial remainder is XLEN+1 bits; after a successful subtract it fits in XLEN.
        shifted = {rem_q, quo_q[XLEN-1]};
        borrow  = shifted < {1'b0, dvs_q};
        diff    = shifted[XLEN-1:0] - dvs_q;

        q_fix = qneg_q ? (~quo_q + OneX) : quo_q;
        r_fix = rneg_q ? (~rem_q + OneX) : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        sel_d    = sel_q;
        result_d = result_q;

        case (state_q)
            StIdle: begin
                if (div_req) begin
                    dvs_d   = dvs_abs;
                    quo_d   = dvd_abs;
                    rem_d   = '0;
                    cnt_d   = '0;
                    qneg_d  = div_sign & (dividend[XLEN-1] ^ divisor[XLEN-1]) & (divisor != '0);
                    rneg_d  = dvd_neg;
                    sel_d   = div_res_sel;
                    state_d = StCalc;
`ifdef DIV_FAST_EN
                    if ((dvs_abs == '0) || (dvs_abs > dvd_abs)) begin
                        quo_d   = (dvs_abs == '0) ? '1 : '0;
                        rem_d   = dvd_abs;
                        state_d = StFix;
                    end
`endif
                end
            end
            StCalc: begin
                rem_d = borrow ? shifted[XLEN-1:0] : diff;
                quo_d = {quo_q[XLEN-2:0], ~borrow};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(XLEN - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = sel_q ? r_fix : q_fix;
                state_d  = StDone;
            end
            StDone: begin
                if (div_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (pipe_flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            sel_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            sel_q    <= sel_d;
            result_q <= result_d;
        end
    end

    assign div_valid  = (state_q == StDone);
    assign div_busy   = (state_q == StCalc) || (state_q == StFix);
    assign div_stall  = div_req & ~div_valid;
    assign div_result = result_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: M-extension results, latency, flush, hold and reset.
module tb_ex_div;

`ifdef DIV_FAST_EN
    localparam int ShortLat = 2;
`else
    localparam int ShortLat = 34;
`endif
    localparam int FullLat = 34;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_flush;
    logic        div_req;
    logic        div_sign;
    logic        div_res_sel;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_ack;
    logic        div_stall;
    logic        div_valid;
    logic        div_busy;
    logic [31:0] div_result;

    int n_tests = 0;
    int n_fail  = 0;

    ex_div #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_flush (pipe_flush),
        .div_req    (div_req),
        .div_sign   (div_sign),
        .div_res_sel(div_res_sel),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_ack    (div_ack),
        .div_stall  (div_stall),
        .div_valid  (div_valid),
        .div_busy   (div_busy),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue a divide, scramble operands after acceptance, wait for div_valid and check.
    task automatic issue(input string tag, input logic sgn, input logic sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        div_sign    = sgn;
        div_res_sel = sel;
        dividend    = a;
        divisor     = b;
        div_req     = 1'b1;
        #1;
        chk({tag, " stall_on_req"}, 32'(div_stall), 32'd1);
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            lat = n;
            if (n == 1) begin
                dividend    = ~a;
                divisor     = b ^ 32'h0000_0013;
                div_sign    = ~sgn;
                div_res_sel = ~sel;
            end
            if (div_valid) break;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, div_result, exp);
    endtask

    task automatic retire(input string tag);
        @(negedge clk);
        chk({tag, " stall_in_done"}, 32'(div_stall), 32'd0);
        div_ack = 1'b1;
        @(posedge clk);
        #1;
        div_ack = 1'b0;
        div_req = 1'b0;
        chk({tag, " valid_after_ack"}, 32'(div_valid), 32'd0);
        chk({tag, " busy_after_ack"}, 32'(div_busy), 32'd0);
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic sel,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int exp_lat);
        issue(tag, sgn, sel, a, b, exp, exp_lat);
        retire(tag);
    endtask

    initial begin
        logic [31:0] held;
        rst_n       = 1'b0;
        pipe_flush  = 1'b0;
        div_req     = 1'b0;
        div_sign    = 1'b0;
        div_res_sel = 1'b0;
        dividend    = '0;
        divisor     = '0;
        div_ack     = 1'b0;
        #12;
        chk("reset valid", 32'(div_valid), 32'd0);
        chk("reset busy", 32'(div_busy), 32'd0);
        chk("reset stall", 32'(div_stall), 32'd0);
        chk("reset result", div_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("divu_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, FullLat);
        run_div("remu_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, FullLat);
        run_div("div_m7_2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FullLat);
        run_div("rem_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FullLat);
        run_div("rem_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, FullLat);
        run_div("div_5_0", 1'b1, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, ShortLat);
        run_div("rem_m5_0", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, ShortLat);
        run_div("divu_5_0", 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, ShortLat);
        run_div("div_ovf", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FullLat);
        run_div("rem_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, FullLat);
        run_div("divu_7_100", 1'b0, 1'b0, 32'd7, 32'd100, 32'd0, ShortLat);
        run_div("remu_7_100", 1'b0, 1'b1, 32'd7, 32'd100, 32'd7, ShortLat);
        run_div("divu_big", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, FullLat);

        // Flush ten cycles into CALC alongside a fresh request.
        @(negedge clk);
        div_sign    = 1'b0;
        div_res_sel = 1'b0;
        dividend    = 32'd1000;
        divisor     = 32'd10;
        div_req     = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        chk("flush busy_before", 32'(div_busy), 32'd1);
        @(negedge clk);
        pipe_flush = 1'b1;
        dividend   = 32'h1234_5678;
        divisor    = 32'h0000_0100;
        @(posedge clk);
        #1;
        chk("flush busy", 32'(div_busy), 32'd0);
        chk("flush valid", 32'(div_valid), 32'd0);
        pipe_flush = 1'b0;
        div_req    = 1'b0;
        @(posedge clk);
        #1;
        chk("flush idle_valid", 32'(div_valid), 32'd0);
        chk("flush idle_busy", 32'(div_busy), 32'd0);
        run_div("after_flush", 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0100, 32'h0012_3456, FullLat);

        // Hold DONE without ack for five cycles.
        issue("hold", 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, FullLat);
        held = 32'h0DEA_DBEE;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold result", div_result, held);
            chk("hold valid", 32'(div_valid), 32'd1);
            chk("hold stall", 32'(div_stall), 32'd0);
        end
        retire("hold");

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        div_sign    = 1'b0;
        div_res_sel = 1'b0;
        dividend    = 32'd100;
        divisor     = 32'd7;
        div_req     = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_mid busy_before", 32'(div_busy), 32'd1);
        #2;
        rst_n   = 1'b0;
        div_req = 1'b0;
        #1;
        chk("rst_mid busy", 32'(div_busy), 32'd0);
        chk("rst_mid valid", 32'(div_valid), 32'd0);
        chk("rst_mid stall", 32'(div_stall), 32'd0);
        chk("rst_mid result", div_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_div("after_rst", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, FullLat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
